// File: rtl/textbuf_writer.sv
// textbuf_writer: byte-stream front end for the single-port character RAM.
// Accepts bytes over valid/ready, tracks a cursor, and turns printable bytes
// and control codes into RAM writes. Also handles full-screen clear and
// scroll-up. Scroll copies each cell with a read, a wait for the RAM's
// registered read data, and then a write.
module textbuf_writer #(
  parameter int COL_BITS   = 5,
  parameter int ROW_BITS   = 4,
  parameter int data_width = 8
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         in_valid,
  input  logic [7:0]                   in_data,
  output logic                         in_ready,
  output logic [COL_BITS+ROW_BITS-1:0] ram_addr,
  output logic                         ram_we,
  output logic [data_width-1:0]        ram_din,
  input  logic [data_width-1:0]        ram_dout,
  output logic [COL_BITS-1:0]          cursor_col,
  output logic [ROW_BITS-1:0]          cursor_row,
  output logic                         busy
);

  localparam int addr_width = COL_BITS + ROW_BITS;

  // One row's worth of cells. Used as the first scroll source and as the
  // distance from each source cell back to its destination.
  localparam logic [addr_width-1:0] ROW_STRIDE = addr_width'(1 << COL_BITS);
  // Address of column 0 in the bottom row.
  localparam logic [addr_width-1:0] LAST_ROW_BASE = {{ROW_BITS{1'b1}}, {COL_BITS{1'b0}}};
  localparam logic [data_width-1:0] BLANK = data_width'(8'h20);

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SCR_RD,
    S_SCR_WAIT,
    S_SCR_WR,
    S_SCR_BLANK
  } state_t;

  state_t                state_q, state_d;
  logic [addr_width-1:0] cnt_q,   cnt_d;   // clear / scroll / blank address
  logic [addr_width-1:0] addr_q,  addr_d;
  logic                  we_q,    we_d;
  logic [data_width-1:0] din_q,   din_d;
  logic [COL_BITS-1:0]   col_q,   col_d;
  logic [ROW_BITS-1:0]   row_q,   row_d;

  logic printable;
  logic col_last;
  logic row_last;

  assign printable = (in_data >= 8'h20) && (in_data <= 8'h7E);
  assign col_last  = (col_q == {COL_BITS{1'b1}});
  assign row_last  = (row_q == {ROW_BITS{1'b1}});

  assign in_ready   = (state_q == S_IDLE);
  assign busy       = !in_ready;
  assign ram_addr   = addr_q;
  assign ram_we     = we_q;
  assign ram_din    = din_q;
  assign cursor_col = col_q;
  assign cursor_row = row_q;

  // State and output registers; synchronous reset restarts the screen clear.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!resetn) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      din_q   <= BLANK;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      din_q   <= din_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  // Next-state logic: byte decode in IDLE, and the clear and scroll sequencers.
  always_comb begin
    // NOTE: every _d gets a default first, so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = 1'b0;
    din_d   = din_q;
    col_d   = col_q;
    row_d   = row_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (printable) begin
            we_d   = 1'b1;
            addr_d = {row_q, col_q};
            din_d  = data_width'(in_data);
            col_d  = col_q + 1'b1;          // wraps to 0 on the last column
            if (col_last) begin
              if (row_last) begin
                state_d = S_SCR_RD;
                cnt_d   = ROW_STRIDE;
              end else begin
                row_d = row_q + 1'b1;
              end
            end
          end else begin
            case (in_data)
              CH_CR: col_d = '0;
              CH_LF: begin
                col_d = '0;
                if (row_last) begin
                  state_d = S_SCR_RD;
                  cnt_d   = ROW_STRIDE;
                end else begin
                  row_d = row_q + 1'b1;
                end
              end
              CH_BS: begin
                if (col_q != '0) begin
                  col_d  = col_q - 1'b1;
                  we_d   = 1'b1;
                  addr_d = {row_q, col_q - 1'b1};
                  din_d  = BLANK;
                end
              end
              CH_FF: begin
                // The cursor keeps its value until the clear finishes.
                state_d = S_CLEAR;
                cnt_d   = '0;
              end
              default: ;                    // accepted and dropped
            endcase
          end
        end
      end

      S_CLEAR: begin
        we_d   = 1'b1;
        addr_d = cnt_q;
        din_d  = BLANK;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_d = S_IDLE;
          col_d   = '0;
          row_d   = '0;
        end
      end

      S_SCR_RD: begin
        addr_d  = cnt_q;
        state_d = S_SCR_WAIT;
      end

      // The RAM registers the read address on this edge. Its data is then
      // valid during SCR_WR.
      S_SCR_WAIT: state_d = S_SCR_WR;

      S_SCR_WR: begin
        we_d   = 1'b1;
        addr_d = cnt_q - ROW_STRIDE;
        din_d  = ram_dout;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_d = S_SCR_BLANK;
          cnt_d   = LAST_ROW_BASE;
        end else begin
          state_d = S_SCR_RD;
        end
      end

      S_SCR_BLANK: begin
        we_d   = 1'b1;
        addr_d = cnt_q;
        din_d  = BLANK;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = S_IDLE;
      end

      default: state_d = S_CLEAR;
    endcase
  end

endmodule

// File: tb/tb_textbuf_writer.sv
// Bench for textbuf_writer. It attaches a single-port RAM with a registered
// read and keeps a screen model: a 2-D view of the text buffer plus a cursor.
// The model is updated by the byte rules, and the RAM contents and cursor are
// compared against it.
module tb_textbuf_writer;

  localparam int COLS  = 32;
  localparam int ROWS  = 16;
  localparam int CELLS = COLS * ROWS;
  localparam int SCROLL_CYCLES = 3 * COLS * (ROWS - 1) + COLS;

  logic       clk = 1'b0;
  logic       resetn;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [8:0] ram_addr;
  logic       ram_we;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;
  logic [4:0] cursor_col;
  logic [3:0] cursor_row;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  textbuf_writer dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_din    (ram_din),
    .ram_dout   (ram_dout),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy)
  );

  // Single-port RAM with a registered read.
  logic [7:0] mem [CELLS];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  // ---------------- screen model ----------------
  logic [7:0] scr [ROWS][COLS];
  int m_row, m_col;

  function automatic void model_clear();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) scr[r][c] = 8'h20;
    m_row = 0;
    m_col = 0;
  endfunction

  function automatic void model_scroll();
    for (int r = 0; r < ROWS - 1; r++)
      for (int c = 0; c < COLS; c++) scr[r][c] = scr[r+1][c];
    for (int c = 0; c < COLS; c++) scr[ROWS-1][c] = 8'h20;
  endfunction

  function automatic void model_newline();
    m_col = 0;
    if (m_row == ROWS - 1) model_scroll();
    else m_row++;
  endfunction

  function automatic void model_apply(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      scr[m_row][m_col] = b;
      if (m_col == COLS - 1) model_newline();
      else m_col++;
    end else if (b == 8'h0D) m_col = 0;
    else if (b == 8'h0A) model_newline();
    else if (b == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        scr[m_row][m_col] = 8'h20;
      end
    end else if (b == 8'h0C) model_clear();
  endfunction

  function automatic int screen_diffs();
    int d = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (mem[r*COLS + c] !== scr[r][c]) d++;
    return d;
  endfunction

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for in_ready, present one byte for one edge, and return
  // the RAM command the DUT registered on that edge.
  task automatic send_byte(input logic [7:0] b, output logic we,
                           output logic [8:0] addr, output logic [7:0] din);
    int n = 0;
    while (!in_ready && n < 5000) begin
      tick();
      n++;
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL send_wait: in_ready=%b after %0d cycles, required 1", in_ready, n);
    end
    in_valid = 1'b1;
    in_data  = b;
    tick();
    we   = ram_we;
    addr = ram_addr;
    din  = ram_din;
    in_valid = 1'b0;
    model_apply(b);
  endtask

  task automatic wait_idle(input int bound, output int n);
    n = 0;
    while (busy && n < bound) begin
      tick();
      n++;
    end
  endtask

  function automatic logic [7:0] rand_printable();
    return 8'($urandom_range(32, 126));
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    int n;
    int d;
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    model_clear();
    n_cmp++;
    if (busy !== 1'b1 || in_ready !== 1'b0 || ram_we !== 1'b0 ||
        ram_addr !== 9'd0 || ram_din !== 8'h20) begin
      n_bad++;
      $display("FAIL reset_state: busy=%b ready=%b we=%b addr=%0d din=%h, required 1 0 0 0 20",
               busy, in_ready, ram_we, ram_addr, ram_din);
    end
    wait_idle(2000, n);
    n_cmp++;
    if (n !== CELLS) begin
      n_bad++;
      $display("FAIL reset_clear_len: busy for %0d cycles, required %0d", n, CELLS);
    end
    n_cmp++;
    if (cursor_row !== 4'd0 || cursor_col !== 5'd0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_cursor: row=%0d col=%0d ready=%b, required 0 0 1",
               cursor_row, cursor_col, in_ready);
    end
    tick();
    d = screen_diffs();
    n_cmp++;
    if (d != 0 || ram_we !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_screen: %0d cells differ, we=%b, required 0 diffs we=0", d, ram_we);
    end
  endtask

  task automatic test_back_to_back();
    logic r0, r1;
    logic we0, we1;
    logic [8:0] a0, a1;
    logic [7:0] d0, d1;
    in_valid = 1'b1;
    in_data  = 8'h48;
    r0 = in_ready;
    tick();
    we0 = ram_we; a0 = ram_addr; d0 = ram_din;
    model_apply(8'h48);
    in_data = 8'h69;
    r1 = in_ready;
    tick();
    we1 = ram_we; a1 = ram_addr; d1 = ram_din;
    model_apply(8'h69);
    in_valid = 1'b0;
    n_cmp++;
    if (r0 !== 1'b1 || r1 !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_ready: ready=%b,%b, required 1,1", r0, r1);
    end
    n_cmp++;
    if (we0 !== 1'b1 || a0 !== 9'd0 || d0 !== 8'h48) begin
      n_bad++;
      $display("FAIL b2b_first: we=%b addr=%0d din=%h, required 1 0 48", we0, a0, d0);
    end
    n_cmp++;
    if (we1 !== 1'b1 || a1 !== 9'd1 || d1 !== 8'h69) begin
      n_bad++;
      $display("FAIL b2b_second: we=%b addr=%0d din=%h, required 1 1 69", we1, a1, d1);
    end
    n_cmp++;
    if (cursor_row !== 4'd0 || cursor_col !== 5'd2) begin
      n_bad++;
      $display("FAIL b2b_cursor: row=%0d col=%0d, required 0 2", cursor_row, cursor_col);
    end
  endtask

  task automatic test_wrap_and_controls();
    logic we;
    logic [8:0] addr;
    logic [7:0] din;
    logic [7:0] ctl [3];
    ctl[0] = 8'h0D; ctl[1] = 8'h0A; ctl[2] = 8'h08;
    for (int i = 0; i < 3; i++) send_byte(8'h0A, we, addr, din);
    for (int i = 0; i < COLS - 1; i++) send_byte(rand_printable(), we, addr, din);
    n_cmp++;
    if (cursor_row !== 4'd3 || cursor_col !== 5'd31) begin
      n_bad++;
      $display("FAIL wrap_setup: row=%0d col=%0d, required 3 31", cursor_row, cursor_col);
    end
    send_byte(8'h41, we, addr, din);
    n_cmp++;
    if (we !== 1'b1 || addr !== 9'd127 || din !== 8'h41) begin
      n_bad++;
      $display("FAIL wrap_write: we=%b addr=%0d din=%h, required 1 127 41", we, addr, din);
    end
    n_cmp++;
    if (cursor_row !== 4'd4 || cursor_col !== 5'd0) begin
      n_bad++;
      $display("FAIL wrap_cursor: row=%0d col=%0d, required 4 0", cursor_row, cursor_col);
    end
    for (int i = 0; i < 3; i++) begin
      send_byte(ctl[i], we, addr, din);
      n_cmp++;
      if (we !== 1'b0) begin
        n_bad++;
        $display("FAIL ctl_no_write: byte %h gave we=%b, required 0", ctl[i], we);
      end
    end
    n_cmp++;
    if (cursor_row !== 4'd5 || cursor_col !== 5'd0) begin
      n_bad++;
      $display("FAIL ctl_cursor: row=%0d col=%0d, required 5 0", cursor_row, cursor_col);
    end
    // Backspace with col>0 blanks the cell it moves onto.
    send_byte(8'h78, we, addr, din);
    send_byte(8'h08, we, addr, din);
    n_cmp++;
    if (we !== 1'b1 || addr !== 9'd160 || din !== 8'h20 || cursor_col !== 5'd0) begin
      n_bad++;
      $display("FAIL bs_write: we=%b addr=%0d din=%h col=%0d, required 1 160 20 0",
               we, addr, din, cursor_col);
    end
  endtask

  task automatic test_scroll();
    logic we;
    logic [8:0] addr;
    logic [7:0] din;
    int n;
    int d;
    int blanks;
    send_byte(8'h0C, we, addr, din);
    wait_idle(2000, n);
    for (int r = 0; r < ROWS - 1; r++)
      for (int c = 0; c < COLS; c++) send_byte(8'(8'h41 + r), we, addr, din);
    for (int c = 0; c < COLS - 1; c++) send_byte(8'h50, we, addr, din);
    send_byte(8'h5A, we, addr, din);
    n_cmp++;
    if (we !== 1'b1 || addr !== 9'd511 || din !== 8'h5A) begin
      n_bad++;
      $display("FAIL scroll_trigger: we=%b addr=%0d din=%h, required 1 511 5a", we, addr, din);
    end
    wait_idle(3000, n);
    n_cmp++;
    if (n !== SCROLL_CYCLES) begin
      n_bad++;
      $display("FAIL scroll_len: busy for %0d cycles, required %0d", n, SCROLL_CYCLES);
    end
    n_cmp++;
    if (cursor_row !== 4'd15 || cursor_col !== 5'd0) begin
      n_bad++;
      $display("FAIL scroll_cursor: row=%0d col=%0d, required 15 0", cursor_row, cursor_col);
    end
    tick();
    n_cmp++;
    if (mem[14*COLS + 31] !== 8'h5A || mem[0] !== 8'h42 || mem[13*COLS + 5] !== 8'h4F) begin
      n_bad++;
      $display("FAIL scroll_cells: (14,31)=%h (0,0)=%h (13,5)=%h, required 5a 42 4f",
               mem[14*COLS + 31], mem[0], mem[13*COLS + 5]);
    end
    blanks = 0;
    for (int c = 0; c < COLS; c++) if (mem[15*COLS + c] === 8'h20) blanks++;
    n_cmp++;
    if (blanks != COLS) begin
      n_bad++;
      $display("FAIL scroll_blank_row: %0d blank cells in row 15, required %0d", blanks, COLS);
    end
    d = screen_diffs();
    n_cmp++;
    if (d != 0) begin
      n_bad++;
      $display("FAIL scroll_screen: %0d cells differ, required 0", d);
    end
  endtask

  task automatic test_hold_valid();
    logic we;
    logic [8:0] addr;
    logic [7:0] din;
    logic [7:0] c1;
    int n;
    int d;
    for (int c = 0; c < COLS - 1; c++) send_byte(rand_printable(), we, addr, din);
    c1 = rand_printable();
    in_valid = 1'b1;
    in_data  = c1;
    tick();
    model_apply(c1);
    in_data = 8'h51;
    n = 0;
    while (!in_ready && n < 3000) begin
      tick();
      n++;
    end
    n_cmp++;
    if (n !== SCROLL_CYCLES) begin
      n_bad++;
      $display("FAIL hold_stall: not ready for %0d cycles, required %0d", n, SCROLL_CYCLES);
    end
    tick();
    in_valid = 1'b0;
    model_apply(8'h51);
    n_cmp++;
    if (ram_we !== 1'b1 || ram_addr !== 9'd480 || ram_din !== 8'h51) begin
      n_bad++;
      $display("FAIL hold_first_byte: we=%b addr=%0d din=%h, required 1 480 51",
               ram_we, ram_addr, ram_din);
    end
    tick();
    d = screen_diffs();
    n_cmp++;
    if (d != 0) begin
      n_bad++;
      $display("FAIL hold_screen: %0d cells differ, required 0", d);
    end
  endtask

  task automatic test_clear_reset();
    logic we;
    logic [8:0] addr;
    logic [7:0] din;
    int k;
    int n;
    int d;
    for (int i = 0; i < 5; i++) send_byte(rand_printable(), we, addr, din);
    send_byte(8'h0C, we, addr, din);
    n_cmp++;
    if (busy !== 1'b1 || cursor_row !== 4'd15 || cursor_col !== 5'd6) begin
      n_bad++;
      $display("FAIL ff_hold_cursor: busy=%b row=%0d col=%0d, required 1 15 6",
               busy, cursor_row, cursor_col);
    end
    k = $urandom_range(10, 300);
    repeat (k) tick();
    n_cmp++;
    if (ram_we !== 1'b1 || ram_addr !== 9'(k - 1)) begin
      n_bad++;
      $display("FAIL ff_progress: we=%b addr=%0d, required 1 %0d", ram_we, ram_addr, k - 1);
    end
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    n_cmp++;
    if (ram_we !== 1'b0 || ram_addr !== 9'd0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_reset: we=%b addr=%0d busy=%b, required 0 0 1", ram_we, ram_addr, busy);
    end
    wait_idle(2000, n);
    n_cmp++;
    if (n !== CELLS || cursor_row !== 4'd0 || cursor_col !== 5'd0) begin
      n_bad++;
      $display("FAIL restart_clear: busy %0d cycles row=%0d col=%0d, required %0d 0 0",
               n, cursor_row, cursor_col, CELLS);
    end
    tick();
    d = screen_diffs();
    n_cmp++;
    if (d != 0) begin
      n_bad++;
      $display("FAIL restart_screen: %0d cells differ, required 0", d);
    end
  endtask

  task automatic test_random();
    logic we;
    logic [8:0] addr;
    logic [7:0] din;
    logic [7:0] b;
    int p;
    int n;
    int d;
    for (int i = 0; i < 200; i++) begin
      p = $urandom_range(0, 99);
      if (p < 72) b = rand_printable();
      else if (p < 80) b = 8'h0D;
      else if (p < 85) b = 8'h0A;
      else if (p < 93) b = 8'h08;
      else if (p < 94) b = 8'h0C;
      else if (p < 97) b = 8'($urandom_range(127, 255));
      else b = 8'h1B;
      send_byte(b, we, addr, din);
    end
    wait_idle(3000, n);
    tick();
    d = screen_diffs();
    n_cmp++;
    if (d != 0) begin
      n_bad++;
      $display("FAIL random_screen: %0d cells differ, required 0", d);
    end
    n_cmp++;
    if (cursor_row !== 4'(m_row) || cursor_col !== 5'(m_col)) begin
      n_bad++;
      $display("FAIL random_cursor: row=%0d col=%0d, required %0d %0d",
               cursor_row, cursor_col, m_row, m_col);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn   = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    test_reset();
    test_back_to_back();
    test_wrap_and_controls();
    test_scroll();
    test_hold_valid();
    test_clear_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
